// File: rtl/uart_rx_fifo.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// uart_rx_fifo
//
// 8N1 serial receiver (LSB first, idle high) feeding a show-ahead FIFO.
// Bit timing comes from an internal divider of CLK_DIV clocks per bit. The
// start bit is confirmed at mid-bit. Data and stop bits are then sampled one
// full bit period apart. A bad stop bit raises frame_err. A good byte that
// finds the FIFO full raises overrun, unless a pop frees a slot in the same
// cycle.
//
// Parameters
//   CLK_DIV   clock cycles per bit (8..65535)
//   FIFO_AW   FIFO address width, depth = 2**FIFO_AW
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   rx_in      asynchronous serial line, idle high
//   rd_en      pop the head entry (ignored while empty)
//   rd_data    head byte, valid while empty = 0 (reads 0x00 when empty)
//   empty      FIFO holds no bytes
//   full       FIFO holds 2**FIFO_AW bytes
//   count      current occupancy
//   frame_err  one-cycle pulse: stop bit sampled low, byte discarded
//   overrun    one-cycle pulse: good byte dropped because FIFO full
// -----------------------------------------------------------------------------
module uart_rx_fifo #(
    parameter int CLK_DIV = 5208,
    parameter int FIFO_AW = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx_in,
    input  logic             rd_en,
    output logic [7:0]       rd_data,
    output logic             empty,
    output logic             full,
    output logic [FIFO_AW:0] count,
    output logic             frame_err,
    output logic             overrun
);

    localparam int               DEPTH     = 1 << FIFO_AW;
    localparam logic [15:0]      HALF_LAST = 16'(CLK_DIV / 2 - 1);
    localparam logic [15:0]      BIT_LAST  = 16'(CLK_DIV - 1);
    localparam logic [FIFO_AW:0] DEPTH_CNT = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

    // ---------------------------------------------------------------------
    // Input synchronizer
    // ---------------------------------------------------------------------
    logic       rx_meta;
    logic       rx_s;
    // Ones shift in after reset. sync_vld[1] marks the point where rx_s
    // carries the real line level instead of the reset value.
    logic [1:0] sync_vld;

    // NOTE: every clocked block uses non-blocking assignments so that all
    // registers update from values sampled at the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta  <= 1'b1;
            rx_s     <= 1'b1;
            sync_vld <= 2'b00;
        end else begin
            rx_meta  <= rx_in;
            rx_s     <= rx_meta;
            sync_vld <= {sync_vld[0], 1'b1};
        end
    end

    // ---------------------------------------------------------------------
    // Receive FSM
    // ---------------------------------------------------------------------
    rx_state_t         state;
    logic [15:0]       div_cnt;
    logic [2:0]        bit_idx;
    logic [7:0]        shreg;
    // A start bit is accepted only after the line has really been seen high.
    // This covers a line held low after a framing error or across a reset.
    logic              armed;

    logic              stop_hit;
    logic              push;
    logic              pop;
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;

    assign empty    = (count == '0);
    assign full     = (count == DEPTH_CNT);
    assign pop      = rd_en && !empty;
    assign stop_hit = (state == STOP) && (div_cnt == BIT_LAST);
    // A pop in the same cycle frees the slot a full FIFO would otherwise lack.
    assign push     = stop_hit && rx_s && (!full || pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            div_cnt   <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            armed     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            case (state)
                IDLE: begin
                    if (!armed) begin
                        armed <= rx_s && sync_vld[1];
                    end else if (!rx_s) begin
                        state   <= START;
                        div_cnt <= '0;
                    end
                end
                START: begin
                    if (div_cnt == HALF_LAST) begin
                        if (rx_s) begin
                            state <= IDLE;          // glitch, not a start bit
                        end else begin
                            state   <= DATA;
                            div_cnt <= '0;
                            bit_idx <= '0;
                        end
                    end else begin
                        div_cnt <= div_cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (div_cnt == BIT_LAST) begin
                        shreg[bit_idx] <= rx_s;
                        div_cnt        <= '0;
                        bit_idx        <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end
                    end else begin
                        div_cnt <= div_cnt + 16'd1;
                    end
                end
                STOP: begin
                    if (div_cnt == BIT_LAST) begin
                        state <= IDLE;
                        if (rx_s) begin
                            armed   <= 1'b1;
                            overrun <= full && !pop;
                        end else begin
                            frame_err <= 1'b1;
                            armed     <= 1'b0;
                        end
                    end else begin
                        div_cnt <= div_cnt + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // FIFO
    // ---------------------------------------------------------------------
    logic [7:0] mem [DEPTH];

    // NOTE: the storage array has no reset. Pointers and count define which
    // words are valid, so a reset that empties the FIFO is enough.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= shreg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Show-ahead head word. It reads 0x00 while empty so that reset gives a
    // defined value even though the array itself is not reset.
    assign rd_data = empty ? 8'h00 : mem[rd_ptr];

endmodule

// File: tb/tb_uart_rx_fifo.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_uart_rx_fifo
//
// Self-checking bench for uart_rx_fifo with CLK_DIV=16 and a 16-entry FIFO.
// Frames are driven bit-by-bit on rx_in. Expected FIFO contents are kept in a
// byte queue. Flag pulses are counted cycle-by-cycle and compared with
// expected totals derived from each frame's stop bit and the queue occupancy.
// -----------------------------------------------------------------------------
module tb_uart_rx_fifo;

    localparam int CLK_DIV = 16;
    localparam int FIFO_AW = 4;
    localparam int DEPTH   = 1 << FIFO_AW;

    logic             clk;
    logic             rst;
    logic             rx_in;
    logic             rd_en;
    logic [7:0]       rd_data;
    logic             empty;
    logic             full;
    logic [FIFO_AW:0] count;
    logic             frame_err;
    logic             overrun;

    uart_rx_fifo #(.CLK_DIV(CLK_DIV), .FIFO_AW(FIFO_AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_in     (rx_in),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .empty     (empty),
        .full      (full),
        .count     (count),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Cycles during which each flag was high.
    int ferr_seen = 0;
    int ovr_seen  = 0;
    int exp_ferr  = 0;
    int exp_ovr   = 0;

    always @(posedge clk) begin
        if (frame_err) ferr_seen <= ferr_seen + 1;
        if (overrun)   ovr_seen  <= ovr_seen + 1;
    end

    // Reference FIFO contents.
    logic [7:0] q[$];

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         exp_count;
        logic [7:0] exp_head;
        int         exp_ferr;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one frame starting at a negedge; returns at the negedge that ends
    // the stop bit, leaving the line high.
    task automatic send_frame(input logic [7:0] d, input logic stop);
        rx_in = 1'b0;
        repeat (CLK_DIV) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            rx_in = d[k];
            repeat (CLK_DIV) @(negedge clk);
        end
        rx_in = stop;
        repeat (CLK_DIV) @(negedge clk);
        rx_in = 1'b1;
    endtask

    // Reference outcome of a completed frame; pop_same means a read was
    // issued on the stop-sample cycle.
    task automatic model_frame(input logic [7:0] d, input logic stop, input logic pop_same);
        if (pop_same && q.size() > 0) void'(q.pop_front());
        if (!stop)                 exp_ferr++;
        else if (q.size() < DEPTH) q.push_back(d);
        else                       exp_ovr++;
    endtask

    task automatic read_check(input string name);
        check({name, "_empty"}, {31'd0, empty}, 32'd0);
        check({name, "_data"}, {24'd0, rd_data}, {24'd0, q[0]});
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        void'(q.pop_front());
    endtask

    task automatic check_flags(input string name);
        check({name, "_ferr_pulses"}, ferr_seen, exp_ferr);
        check({name, "_ovr_pulses"}, ovr_seen, exp_ovr);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        string      msg;
        logic [7:0] b;
        int         waited;
        logic       stop;
        int         npop;

        vecs[0] = '{data: 8'h69, stop: 1'b1, exp_count: 1, exp_head: 8'h69, exp_ferr: 0};
        vecs[1] = '{data: 8'h3C, stop: 1'b0, exp_count: 0, exp_head: 8'h00, exp_ferr: 1};
        vecs[2] = '{data: 8'h3C, stop: 1'b1, exp_count: 1, exp_head: 8'h3C, exp_ferr: 0};
        vecs[3] = '{data: 8'hFF, stop: 1'b1, exp_count: 1, exp_head: 8'hFF, exp_ferr: 0};
        vecs[4] = '{data: 8'h00, stop: 1'b0, exp_count: 0, exp_head: 8'h00, exp_ferr: 1};

        rst   = 1'b1;
        rx_in = 1'b1;
        rd_en = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_empty", {31'd0, empty}, 32'd1);
        check("rst_full", {31'd0, full}, 32'd0);
        check("rst_count", {27'd0, count}, 32'd0);
        check("rst_rd_data", {24'd0, rd_data}, 32'd0);
        check("rst_frame_err", {31'd0, frame_err}, 32'd0);
        check("rst_overrun", {31'd0, overrun}, 32'd0);
        repeat (20) @(negedge clk);

        // Single-frame table
        for (int i = 0; i < 5; i++) begin
            int f0;
            f0 = ferr_seen;
            send_frame(vecs[i].data, vecs[i].stop);
            repeat (4) @(negedge clk);
            check($sformatf("vec%0d_count", i), {27'd0, count}, vecs[i].exp_count);
            check($sformatf("vec%0d_empty", i), {31'd0, empty}, {31'd0, vecs[i].exp_count == 0});
            check($sformatf("vec%0d_ferr", i), ferr_seen - f0, vecs[i].exp_ferr);
            exp_ferr += vecs[i].exp_ferr;
            if (vecs[i].exp_count > 0) begin
                check($sformatf("vec%0d_head", i), {24'd0, rd_data}, {24'd0, vecs[i].exp_head});
                rd_en = 1'b1;
                @(negedge clk);
                rd_en = 1'b0;
                check($sformatf("vec%0d_pop_empty", i), {31'd0, empty}, 32'd1);
                check($sformatf("vec%0d_pop_count", i), {27'd0, count}, 32'd0);
            end
            repeat (10) @(negedge clk);
        end
        check_flags("table");

        // Short low glitch, then a real frame
        rx_in = 1'b0;
        repeat (5) @(negedge clk);
        rx_in = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch_count", {27'd0, count}, 32'd0);
        check_flags("glitch");
        send_frame(8'hA5, 1'b1);
        model_frame(8'hA5, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        check("after_glitch_count", {27'd0, count}, q.size());
        read_check("after_glitch");

        // Back-to-back string with slow draining
        msg = "i like verlog too";
        fork
            begin
                for (int i = 0; i < msg.len(); i++) send_frame(msg[i], 1'b1);
            end
            begin
                for (int i = 0; i < msg.len(); i++) begin
                    repeat (200) @(negedge clk);
                    waited = 0;
                    while (empty && waited < 2000) begin
                        @(negedge clk);
                        waited++;
                    end
                    b = msg[i];
                    check($sformatf("drain%0d_ready", i), {31'd0, empty}, 32'd0);
                    check($sformatf("drain%0d_data", i), {24'd0, rd_data}, {24'd0, b});
                    rd_en = 1'b1;
                    @(negedge clk);
                    rd_en = 1'b0;
                end
            end
        join
        repeat (10) @(negedge clk);
        check("drain_count", {27'd0, count}, 32'd0);
        check_flags("drain");

        // Fill to full, then overrun
        for (int i = 0; i < DEPTH; i++) begin
            send_frame(8'(i), 1'b1);
            model_frame(8'(i), 1'b1, 1'b0);
        end
        repeat (4) @(negedge clk);
        check("fill_full", {31'd0, full}, 32'd1);
        check("fill_count", {27'd0, count}, DEPTH);
        send_frame(8'h10, 1'b1);
        model_frame(8'h10, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        check_flags("overrun");
        check("overrun_count", {27'd0, count}, DEPTH);
        for (int i = 0; i < DEPTH; i++) read_check($sformatf("ovr_read%0d", i));
        check("ovr_drained_empty", {31'd0, empty}, 32'd1);

        // Fill again; pop on the stop-sample cycle of the 17th frame
        for (int i = 0; i < DEPTH; i++) begin
            send_frame(8'(i), 1'b1);
            model_frame(8'(i), 1'b1, 1'b0);
        end
        fork
            send_frame(8'h10, 1'b1);
            begin
                // Stop sample lands on the 155th rising edge after the start
                // bit is driven (2 sync + 1 detect + 8 + 9*16).
                repeat (154) @(negedge clk);
                check("popstop_head", {24'd0, rd_data}, {24'd0, q[0]});
                rd_en = 1'b1;
                @(negedge clk);
                rd_en = 1'b0;
            end
        join
        model_frame(8'h10, 1'b1, 1'b1);
        repeat (4) @(negedge clk);
        check_flags("popstop");
        check("popstop_count", {27'd0, count}, DEPTH);
        for (int i = 0; i < DEPTH; i++) read_check($sformatf("popstop_read%0d", i));

        // Reset during data bit 4 with three bytes queued
        send_frame(8'h11, 1'b1); model_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1); model_frame(8'h22, 1'b1, 1'b0);
        send_frame(8'h33, 1'b1); model_frame(8'h33, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        check("prerst_count", {27'd0, count}, 32'd3);
        fork
            send_frame(8'h81, 1'b1);
            begin
                repeat (88) @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check("midrst_count", {27'd0, count}, 32'd0);
                check("midrst_empty", {31'd0, empty}, 32'd1);
                check("midrst_ferr", {31'd0, frame_err}, 32'd0);
                check("midrst_ovr", {31'd0, overrun}, 32'd0);
            end
        join
        q.delete();
        repeat (30) @(negedge clk);
        check("postrst_count", {27'd0, count}, 32'd0);
        check_flags("postrst");
        send_frame(8'h81, 1'b1);
        model_frame(8'h81, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        check("postrst_frame_count", {27'd0, count}, 32'd1);
        read_check("postrst_frame");

        // Randomized frames and reads against the queue model
        for (int i = 0; i < 48; i++) begin
            b    = 8'($urandom);
            stop = ($urandom_range(0, 5) != 0);
            send_frame(b, stop);
            model_frame(b, stop, 1'b0);
            repeat (4) @(negedge clk);
            check($sformatf("rnd%0d_count", i), {27'd0, count}, q.size());
            npop = $urandom_range(0, 1);
            for (int j = 0; j < npop; j++) begin
                if (q.size() > 0) read_check($sformatf("rnd%0d_read", i));
            end
            repeat ($urandom_range(0, 20)) @(negedge clk);
        end
        check_flags("random");
        while (q.size() > 0) read_check("final_read");
        check("final_empty", {31'd0, empty}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
